// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch/dispatch controller: fetches one 16-bit word at the PC, decodes the opcode,
// and hands it to the ALU or misc execution FSM, guarding EXEC with a watchdog.
module instr_fetch_ctrl #(
    parameter int WDOG_MAX = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    input  logic        mem_rdy,
    input  logic [15:0] mem_data,
    output logic [15:0] ir,
    output logic        alu_start,
    output logic        misc_start,
    input  logic        pc_inc,
    input  logic        pc_load,
    input  logic [7:0]  pc_load_val,
    input  logic        exec_done,
    output logic        halted,
    output logic        fault
);

    localparam int WW = (WDOG_MAX > 1) ? $clog2(WDOG_MAX) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_MAX - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, DECODE, EXEC, HALT} state_t;

    state_t        state;
    logic [7:0]    pc;
    logic [WW-1:0] wdog;

    assign mem_addr = pc;

    // ir doubles as the instruction register: loaded on capture, zeroed whenever
    // no instruction is in DECODE/EXEC so downstream FSMs see a non-ALU opcode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= 8'h00;
            ir         <= 16'h0000;
            wdog       <= '0;
            mem_rd     <= 1'b0;
            alu_start  <= 1'b0;
            misc_start <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            alu_start  <= 1'b0;
            misc_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state  <= FETCH;
                        mem_rd <= 1'b1;
                    end
                end
                FETCH: state <= WAIT_MEM;
                WAIT_MEM: begin
                    if (mem_rdy) begin
                        ir    <= mem_data;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (ir[15:12] == 4'h0) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        ir     <= 16'h0000;
                    end else begin
                        state      <= EXEC;
                        wdog       <= '0;
                        alu_start  <= (ir[15:12] >= 4'h9);
                        misc_start <= (ir[15:12] <  4'h9);
                    end
                end
                EXEC: begin
                    if (pc_load)
                        pc <= pc_load_val;
                    else if (pc_inc)
                        pc <= pc + 8'h01;
                    // completion beats the watchdog when both land in the same cycle
                    if (exec_done) begin
                        ir <= 16'h0000;
                        if (run) begin
                            state  <= FETCH;
                            mem_rd <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (wdog == WDOG_LAST) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        ir     <= 16'h0000;
                        state  <= HALT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: expected dispatches are queued when memory responds
// and checked when the controller issues a start pulse or halts.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, mem_rdy, pc_inc, pc_load, exec_done;
    logic [15:0] mem_data;
    logic [7:0]  pc_load_val;
    logic [7:0]  mem_addr;
    logic        mem_rd, alu_start, misc_start, halted, fault;
    logic [15:0] ir;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        alu;
        logic        misc;
        logic        halt;
        logic [15:0] ir;
    } disp_t;

    disp_t sb[$];

    instr_fetch_ctrl #(.WDOG_MAX(31)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdy(mem_rdy), .mem_data(mem_data),
        .ir(ir), .alu_start(alu_start), .misc_start(misc_start),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .exec_done(exec_done), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_addr"}, mem_addr, 8'h00);
        chk({tag, "_rd"}, mem_rd, 1'b0);
        chk({tag, "_ir"}, ir, 16'h0000);
        chk({tag, "_starts"}, {alu_start, misc_start}, 2'b00);
        chk({tag, "_halted"}, halted, 1'b0);
        chk({tag, "_fault"}, fault, 1'b0);
    endtask

    // Waits (bounded) for a read request, checks the address and the one-cycle strobe.
    task automatic wait_rd(input logic [7:0] a);
        int n = 0;
        while (!mem_rd && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_rd", mem_rd, 1'b1);
        chk("fetch_addr", mem_addr, a);
        @(negedge clk);
        chk("rd_one_cycle", mem_rd, 1'b0);
    endtask

    task automatic respond(input logic [15:0] d, input int lat);
        disp_t e;
        repeat (lat - 1) @(negedge clk);
        mem_rdy  = 1'b1;
        mem_data = d;
        e.halt = (d[15:12] == 4'h0);
        e.alu  = (d[15:12] >= 4'h9);
        e.misc = !e.halt && !e.alu;
        e.ir   = e.halt ? 16'h0000 : d;
        sb.push_back(e);
        @(negedge clk);
        mem_rdy  = 1'b0;
        mem_data = 16'($urandom);
    endtask

    task automatic fetch(input logic [7:0] a, input logic [15:0] d, input int lat);
        wait_rd(a);
        respond(d, lat);
    endtask

    // Pops the oldest expected dispatch once the DUT pulses a start or halts.
    task automatic dispatch();
        disp_t e;
        int n = 0;
        while (!(alu_start || misc_start || halted) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("alu_start", alu_start, e.alu);
            chk("misc_start", misc_start, e.misc);
            chk("halted", halted, e.halt);
            chk("ir_dispatch", ir, e.ir);
            if (!e.halt) begin
                @(negedge clk);
                chk("start_single", {alu_start, misc_start}, 2'b00);
            end
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mem_rdy = 1'b0; mem_data = 16'h0000;
        pc_inc = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00; exec_done = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outs("rst0");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rd", mem_rd, 1'b0);

        // ALU instruction, single pc_inc, done after 9 cycles
        run = 1'b1;
        fetch(8'h00, 16'h9083, 2);
        dispatch();
        pc_inc = 1'b1;
        @(negedge clk);
        pc_inc = 1'b0;
        chk("pc_inc_addr", mem_addr, 8'h01);
        for (int i = 0; i < 6; i++) begin
            chk("ir_stable", ir, 16'h9083);
            @(negedge clk);
        end
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;

        // misc instruction, pc_load beats pc_inc
        fetch(8'h01, 16'h3041, 3);
        dispatch();
        pc_load = 1'b1; pc_load_val = 8'h40; pc_inc = 1'b1;
        @(negedge clk);
        pc_load = 1'b0; pc_inc = 1'b0;
        chk("pc_load_prio", mem_addr, 8'h40);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;

        // reset while waiting on memory discards the instruction
        wait_rd(8'h40);
        rst = 1'b1; run = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        mem_rdy = 1'b1; mem_data = 16'h9111;
        @(negedge clk);
        mem_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_starts", {alu_start, misc_start}, 2'b00);
            chk("post_rst_ir", ir, 16'h0000);
            chk("post_rst_rd", mem_rd, 1'b0);
            @(negedge clk);
        end
        chk("post_rst_addr", mem_addr, 8'h00);

        // PC wrap, then run dropped mid-instruction
        run = 1'b1;
        fetch(8'h00, 16'h1234, 1);
        dispatch();
        pc_load = 1'b1; pc_load_val = 8'hFF;
        @(negedge clk);
        pc_load = 1'b0;
        chk("pc_ff", mem_addr, 8'hFF);
        pc_inc = 1'b1;
        @(negedge clk);
        chk("pc_wrap", mem_addr, 8'h00);
        run = 1'b0;
        @(negedge clk);
        pc_inc = 1'b0;
        chk("pc_after_wrap", mem_addr, 8'h01);
        chk("run_low_no_abort", ir, 16'h1234);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("idle_after_done_rd", mem_rd, 1'b0);
        chk("idle_after_done_ir", ir, 16'h0000);
        pc_inc = 1'b1; pc_load = 1'b1; pc_load_val = 8'h77; exec_done = 1'b1;
        @(negedge clk);
        pc_inc = 1'b0; pc_load = 1'b0; exec_done = 1'b0;
        @(negedge clk);
        chk("idle_ignores_pc", mem_addr, 8'h01);
        chk("idle_ignores_done", mem_rd, 1'b0);

        // exec_done on the last watchdog cycle wins
        run = 1'b1;
        fetch(8'h01, 16'hA123, 2);
        dispatch();
        repeat (29) @(negedge clk);
        chk("wd31_pre_halted", halted, 1'b0);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("wd31_fault", fault, 1'b0);
        chk("wd31_halted", halted, 1'b0);

        // watchdog expiry after 31 EXEC cycles
        fetch(8'h01, 16'hB000, 2);
        dispatch();
        repeat (29) @(negedge clk);
        chk("wd_cyc31_fault", fault, 1'b0);
        chk("wd_cyc31_halted", halted, 1'b0);
        @(negedge clk);
        chk("wd_fault", fault, 1'b1);
        chk("wd_halted", halted, 1'b1);
        chk("wd_ir", ir, 16'h0000);
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        repeat (3) @(negedge clk);
        chk("wd_sticky_fault", fault, 1'b1);
        chk("wd_stay_halted", halted, 1'b1);
        chk("wd_halt_rd", mem_rd, 1'b0);
        rst = 1'b1; run = 1'b0;
        #1;
        chk_reset_outs("rst_fault");
        @(negedge clk);
        rst = 1'b0;

        // opcode 0 halts with no start pulse; run toggles are ignored
        run = 1'b1;
        fetch(8'h00, 16'h0000, 2);
        dispatch();
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            @(negedge clk);
            chk("halt_stays", halted, 1'b1);
            chk("halt_no_rd", mem_rd, 1'b0);
            chk("halt_no_start", {alu_start, misc_start}, 2'b00);
        end
        chk("halt_no_fault", fault, 1'b0);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
